// File: rtl/hazard_sched_unit_pkg.sv
// Shared types for the pipeline hazard/sequencing controller:
// scoreboard entry layout and EX forwarding-select encodings.
package hazard_sched_unit_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } sb_entry_t;

  // x0 is hardwired, so a write to it never produces a hazard.
  function automatic logic rd_hit(
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] src
  );
    return we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_sched_unit_fwd_select.sv
// EX operand forwarding select: one source register compared
// against the EX/MEM and MEM/WB scoreboard entries.
module hazard_sched_unit_fwd_select
  import hazard_sched_unit_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  logic hit_mem;
  logic hit_wb;

  // The younger result (EX/MEM) shadows the older one.
  assign hit_mem = rd_hit(mem_we, mem_rd, src);
  assign hit_wb  = rd_hit(wb_we, wb_rd, src) & ~hit_mem;

  always_comb begin
    sel = FWD_RF;
    unique case (1'b1)
      hit_mem: sel = FWD_MEM;
      hit_wb:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_sched_unit.sv
// Pipeline sequencing controller: shadow scoreboard of ID/EX,
// EX/MEM, MEM/WB tags driving stalls, flushes and forwarding.
module hazard_sched_unit #(
  parameter int REG_AW = hazard_sched_unit_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  import hazard_sched_unit_pkg::*;

  sb_entry_t ex_q;
  sb_entry_t mem_q;
  sb_entry_t wb_q;
  sb_entry_t id_e;

  logic freeze;
  logic redirect;
  logic loaduse;
  logic stall;
  logic hit1;
  logic hit2;
  logic wb_unused;

  assign id_e = '{
    rs1:      id_rs1,
    rs2:      id_rs2,
    rd:       id_rd,
    regwrite: id_regwrite,
    memread:  id_memread
  };

  assign hit1 = id_uses_rs1
              & rd_hit(ex_q.memread, ex_q.rd, id_rs1);
  assign hit2 = id_uses_rs2
              & rd_hit(ex_q.memread, ex_q.rd, id_rs2);

  assign loaduse  = hit1 | hit2;
  assign freeze   = mem_busy;
  // A redirect squashes the ID instruction, so it also kills the stall.
  assign redirect = ex_redirect & ~freeze;
  assign stall    = loaduse & ~freeze & ~ex_redirect;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    unique case (1'b1)
      freeze: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      redirect: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      stall: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= idex_bubble ? sb_entry_t'('0) : id_e;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze | stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  hazard_sched_unit_fwd_select u_fwd_a (
    .src    (ex_q.rs1),
    .mem_rd (mem_q.rd),
    .mem_we (mem_q.regwrite),
    .wb_rd  (wb_q.rd),
    .wb_we  (wb_q.regwrite),
    .sel    (fwd_a)
  );

  hazard_sched_unit_fwd_select u_fwd_b (
    .src    (ex_q.rs2),
    .mem_rd (mem_q.rd),
    .mem_we (mem_q.regwrite),
    .wb_rd  (wb_q.rd),
    .wb_we  (wb_q.regwrite),
    .sel    (fwd_b)
  );

  // wb keeps the full entry so the retiring tags stay observable.
  assign wb_unused = ^{wb_q.rs1, wb_q.rs2, wb_q.memread};

endmodule
